// File: rtl/io_port.sv
// Host-facing I/O peripheral: input and output FIFOs between host and core.
// Stalls the core when an I/O instruction cannot complete this cycle.
module io_port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

  // Storage is never reset; the head mux hides stale contents.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= wdata;
  end

  assign head = (level != '0) ? mem[rp] : '0;
endmodule

module io_port #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       host_in_data,
  input  logic                   host_in_valid,
  output logic                   host_in_ready,
  output logic [WIDTH-1:0]       read_in,
  input  logic                   proc_rd,
  input  logic [WIDTH-1:0]       write_out,
  input  logic                   proc_wr,
  output logic                   proc_stall,
  output logic [WIDTH-1:0]       host_out_data,
  output logic                   host_out_valid,
  input  logic                   host_out_ready,
  output logic [$clog2(DEPTH):0] in_level,
  output logic [$clog2(DEPTH):0] out_level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic in_push;
  logic in_pop;
  logic out_push;
  logic out_pop;
  logic in_empty;
  logic out_full;

  assign in_empty = (in_level == '0);
  assign out_full = (out_level == FULL);

  assign host_in_ready  = rst & (in_level != FULL);
  assign host_out_valid = (out_level != '0);

  // Either cause blocks both processor-side transfers.
  assign proc_stall = rst & ((proc_rd & in_empty) |
                             (proc_wr & out_full));

  assign in_push  = host_in_valid & host_in_ready;
  assign in_pop   = proc_rd & ~proc_stall & ~in_empty;
  assign out_push = proc_wr & ~proc_stall & ~out_full;
  assign out_pop  = host_out_valid & host_out_ready;

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in (
    .clock (clock),
    .rst   (rst),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (host_in_data),
    .head  (read_in),
    .level (in_level)
  );

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out (
    .clock (clock),
    .rst   (rst),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (write_out),
    .head  (host_out_data),
    .level (out_level)
  );
endmodule

// File: doc/io_port.md
# io_port

Host-facing I/O peripheral for the `load_store` processor: it drives the processor's `read_in` bus and consumes its `write_out` bus. An input FIFO buffers host words until the processor executes an input instruction. An output FIFO captures processor output words until the host drains them. It sits between the processor core and the board/testbench host and stalls the core when an I/O instruction cannot complete.

## Interface
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `WIDTH`, 16: data width; must match the processor datapath.
- `clock` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `host_in_data` in WIDTH: word offered by the host.
- `host_in_valid` in 1: host offers `host_in_data`.
- `host_in_ready` out 1: input FIFO can accept a word.
- `read_in` out WIDTH: input-FIFO head word to the processor.
- `proc_rd` in 1: processor is executing an input instruction this cycle.
- `write_out` in WIDTH: processor output word.
- `proc_wr` in 1: processor is executing an output instruction this cycle.
- `proc_stall` out 1: processor must hold its current instruction.
- `host_out_data` out WIDTH: output-FIFO head word to the host.
- `host_out_valid` out 1: `host_out_data` is valid.
- `host_out_ready` in 1: host accepts `host_out_data`.
- `in_level` out $clog2(DEPTH)+1: input FIFO occupancy.
- `out_level` out $clog2(DEPTH)+1: output FIFO occupancy.

## Operation
- **Reset (`rst`=0, asynchronous):**
  - Both FIFOs are empty; pointers and levels are 0.
  - `host_in_ready`=0, `host_out_valid`=0, `read_in`=0, `host_out_data`=0, `proc_stall`=0.
  - Storage contents are don't-care; no output may expose them.
- **Input FIFO:**
  - `host_in_ready` = `rst` & (`in_level` != DEPTH).
  - Push on `host_in_valid` & `host_in_ready`.
  - `read_in` = head word when `in_level`>0, else 0.
  - Pop on `proc_rd` & ~`proc_stall`.
- **Output FIFO:**
  - Push `write_out` on `proc_wr` & ~`proc_stall`.
  - `host_out_valid` = (`out_level`>0).
  - `host_out_data` = head word when valid, else 0.
  - Pop on `host_out_valid` & `host_out_ready`.
- **Stall:**
  - `proc_stall` = `rst` & ((`proc_rd` & `in_level`==0) | (`proc_wr` & `out_level`==DEPTH)). Combinational, no registered delay.
  - When `proc_stall`=1, neither the processor pop nor the processor push happens, even if only one of `proc_rd`/`proc_wr` caused the stall. Host-side push/pop proceed normally.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Levels are computed separately and range 0..DEPTH.
- **No bypass:** a word pushed in cycle N is never visible at the opposite side in cycle N.
- **Simultaneous push and pop, same FIFO:**
  - 0<level<DEPTH: both happen and the level is unchanged.
  - Level 0: only the push happens (pop blocked or stalled).
  - Level DEPTH: only the pop happens (push blocked or stalled).
- **Overflow/underflow:** the FIFOs can never overflow or underflow. The levels never exceed DEPTH and never go below 0.
- **Reset mid-operation:** all buffered words are discarded immediately, with no partial transfer. After `rst` returns high, `host_in_ready`=1 the same cycle.

## Timing
- Host push at edge N → `read_in` shows the word and `in_level` increments after edge N. Earliest processor pop is at edge N+1.
- Processor push at edge N → `host_out_valid`=1 after edge N. Earliest host pop is at edge N+1.
- `proc_stall` follows `proc_rd`/`proc_wr` within the same cycle; there are no combinational paths from host inputs to `proc_stall`.
- Full-to-non-full:
  - Input side: a pop at edge N raises `host_in_ready` after edge N.
  - Output side: a host pop at edge N clears the stall of a waiting `proc_wr` after edge N, so that push lands at edge N+1.
- Throughput: one word per cycle per direction, sustained at any level.

## Test plan
- **Reset values:** hold `rst`=0 with random inputs. Every output must be 0, including `host_in_ready`. Release reset → `host_in_ready`=1 and both levels =0.
- **Input path:** host pushes 16'h13b0 then 16'h1234; processor asserts `proc_rd` for 2 cycles. `read_in` must read 16'h13b0 then 16'h1234 with no stall. A 3rd `proc_rd` → `proc_stall`=1 and `read_in`=0.
- **Output path, full:** processor writes 16'h000b, 16'h0003, 16'h0001, 16'h0002 with `host_out_ready`=0. `out_level`=4. A 5th `proc_wr` (16'h0005) stalls. Raising `host_out_ready` drains 000b, 0003, 0001, 0002, 0005 in order, and the stall drops the cycle after the first host pop.
- **Wrap-around:** stream 3×DEPTH words through each FIFO with ready/valid toggled pseudo-randomly. Data must be in order, none lost or duplicated, and the levels must match a scoreboard every cycle.
- **Joint stall:** input FIFO empty with the output FIFO non-full; assert `proc_rd` and `proc_wr` together with `write_out`=16'h00aa. `proc_stall`=1 and `out_level` is unchanged until an input word arrives. Then both complete at the same edge.
- **Reset mid-stream:** with 2 words in each FIFO, pulse `rst` low between clock edges. Both levels go to 0 asynchronously, `host_out_valid`=0, and no stale word appears after release.
